// File: rtl/mmsa_if.sv
// mmsa_if: load/index/MAC/SRAM signal bundle for mmsa_ctrl (proto_err present with MMSA_CTRL_PROTO_ERR_EN)
interface mmsa_if;
  logic        in_valid, matrix, in_valid2, i_mat_idx, w_mat_idx, mac_done;
  logic [1:0]  matrix_size, mac_size;
  logic        mem_we, mac_start, busy;
  logic [10:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [3:0]  mac_i_idx, mac_w_idx;
`ifdef MMSA_CTRL_PROTO_ERR_EN
  logic        proto_err;
  modport master (output in_valid, matrix, matrix_size, in_valid2, i_mat_idx, w_mat_idx, mac_done,
                  input mem_we, mem_addr, mem_wdata, mac_start, mac_i_idx, mac_w_idx, mac_size, busy, proto_err);
  modport slave  (input in_valid, matrix, matrix_size, in_valid2, i_mat_idx, w_mat_idx, mac_done,
                  output mem_we, mem_addr, mem_wdata, mac_start, mac_i_idx, mac_w_idx, mac_size, busy, proto_err);
`else
  modport master (output in_valid, matrix, matrix_size, in_valid2, i_mat_idx, w_mat_idx, mac_done,
                  input mem_we, mem_addr, mem_wdata, mac_start, mac_i_idx, mac_w_idx, mac_size, busy);
  modport slave  (input in_valid, matrix, matrix_size, in_valid2, i_mat_idx, w_mat_idx, mac_done,
                  output mem_we, mem_addr, mem_wdata, mac_start, mac_i_idx, mac_w_idx, mac_size, busy);
`endif
endinterface

// File: rtl/mmsa_ctrl.sv
// mmsa_ctrl: serial matrix loader and MAC round sequencer; MMSA_CTRL_PROTO_ERR_EN adds sticky proto_err
module mmsa_ctrl (
  input logic clk,
  input logic rst,
  mmsa_if.slave bus
);
  localparam logic [2:0] IDLE = 3'd0, LOAD = 3'd1, WAIT_IDX = 3'd2, IDX = 3'd3, RUN = 3'd4, BUSY = 3'd5;
  logic [2:0]  state;
  logic [14:0] sr;
  logic [3:0]  bcnt;
  logic [5:0]  elem, last_elem;
  logic [4:0]  mat_no, round;
  logic        full;
  logic [2:0]  ish, wsh;
  logic [1:0]  icnt;
  assign last_elem = bus.mac_size == 2'b00 ? 6'd3 : bus.mac_size == 2'b01 ? 6'd15 : 6'd63;
  assign bus.mac_start = state == RUN;
  assign bus.busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      sr            <= '0;
      bcnt          <= '0;
      elem          <= '0;
      mat_no        <= '0;
      full          <= 1'b0;
      round         <= '0;
      ish           <= '0;
      wsh           <= '0;
      icnt          <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mac_i_idx <= '0;
      bus.mac_w_idx <= '0;
      bus.mac_size  <= '0;
    end else begin
      bus.mem_we <= 1'b0;
      case (state)
        IDLE: if (bus.in_valid) begin
          state        <= LOAD;
          bus.mac_size <= bus.matrix_size;
          sr           <= {sr[13:0], bus.matrix};
          bcnt         <= 4'd1;
          elem         <= '0;
          mat_no       <= '0;
          full         <= 1'b0;
        end
        LOAD: if (!bus.in_valid) begin
          state <= WAIT_IDX;
          bcnt  <= '0;
          round <= '0;
        end else begin
          sr   <= {sr[13:0], bus.matrix};
          bcnt <= bcnt + 4'd1;
          // once all 32 matrices are stored, further words are silently dropped
          if (bcnt == 4'd15 && !full) begin
            bus.mem_we    <= 1'b1;
            bus.mem_wdata <= {sr, bus.matrix};
            bus.mem_addr  <= {mat_no, elem};
            elem          <= elem == last_elem ? 6'd0 : elem + 6'd1;
            mat_no        <= elem == last_elem ? mat_no + 5'd1 : mat_no;
            full          <= elem == last_elem && &mat_no;
          end
        end
        WAIT_IDX: if (bus.in_valid2) begin
          state <= IDX;
          ish   <= {2'b00, bus.i_mat_idx};
          wsh   <= {2'b00, bus.w_mat_idx};
          icnt  <= 2'd1;
        end
        IDX: if (!bus.in_valid2) state <= WAIT_IDX;
        else if (icnt == 2'd3) begin
          state         <= RUN;
          bus.mac_i_idx <= {ish, bus.i_mat_idx};
          bus.mac_w_idx <= {wsh, bus.w_mat_idx};
        end else begin
          ish  <= {ish[1:0], bus.i_mat_idx};
          wsh  <= {wsh[1:0], bus.w_mat_idx};
          icnt <= icnt + 2'd1;
        end
        RUN: state <= BUSY;
        BUSY: if (bus.mac_done) begin
          round <= round + 5'd1;
          state <= round == 5'd15 ? IDLE : WAIT_IDX;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef MMSA_CTRL_PROTO_ERR_EN
  logic err_ev;
  assign err_ev = (state == LOAD && !bus.in_valid && bcnt != 4'd0)
               || (state == LOAD && bus.in_valid && bcnt == 4'd15 && full)
               || (state == IDX && !bus.in_valid2)
               || ((state == RUN || state == BUSY) && (bus.in_valid || bus.in_valid2))
               || (state == WAIT_IDX && bus.in_valid);
  always_ff @(posedge clk) begin
    if (rst) bus.proto_err <= 1'b0;
    else if (err_ev) bus.proto_err <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_mmsa_ctrl.sv
// tb_mmsa_ctrl: directed checks of loading, addressing, index rounds and reset for mmsa_ctrl
module tb_mmsa_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  mmsa_if bus();
  mmsa_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  int n_vec = 0, n_err = 0, wcnt = 0, scnt = 0, nn = 4;
  logic [15:0] dbase = '0, last_data = '0;
  logic [10:0] last_addr = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [15:0] w, input logic [1:0] sz);
    for (int b = 15; b >= 0; b--) begin
      bus.in_valid = 1'b1;
      bus.matrix = w[b];
      bus.matrix_size = sz;
      tick();
    end
  endtask

  task automatic send_idx(input logic [3:0] iv, input logic [3:0] wv);
    for (int b = 3; b >= 0; b--) begin
      bus.in_valid2 = 1'b1;
      bus.i_mat_idx = iv[b];
      bus.w_mat_idx = wv[b];
      tick();
    end
    bus.in_valid2 = 1'b0;
  endtask

  task automatic finish_round(input bit poke);
    for (int c = 0; c < 4; c++) begin
      bus.in_valid2 = poke && c < 2;
      tick();
    end
    bus.in_valid2 = 1'b0;
    bus.mac_done = 1'b1;
    tick();
    bus.mac_done = 1'b0;
  endtask

  always @(negedge clk) begin
    if (bus.mem_we) begin
      chk("wr_addr", {21'd0, bus.mem_addr}, ((wcnt / nn) << 6) | (wcnt % nn));
      chk("wr_data", {16'd0, bus.mem_wdata}, {16'd0, dbase + wcnt[15:0]});
      last_addr = bus.mem_addr;
      last_data = bus.mem_wdata;
      wcnt++;
    end
    if (bus.mac_start) scnt++;
  end

  initial begin
    {bus.in_valid, bus.matrix, bus.matrix_size, bus.in_valid2, bus.i_mat_idx, bus.w_mat_idx, bus.mac_done} = '0;
    tick();
    tick();
    chk("rst_we", bus.mem_we, 0);
    chk("rst_addr", bus.mem_addr, 0);
    chk("rst_wdata", bus.mem_wdata, 0);
    chk("rst_start", bus.mac_start, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_size", bus.mac_size, 0);
    rst = 1'b0;
    nn = 4; dbase = 16'h1000; wcnt = 0;
    for (int k = 0; k < 130; k++) send_word(16'h1000 + k[15:0], 2'b00);
    bus.in_valid = 1'b0;
    tick();
    tick();
    chk("s0_count", wcnt, 128);
    chk("s0_last_addr", last_addr, 11'h7C3);
    chk("s0_last_data", last_data, 16'h107F);
    chk("s0_busy_wait", bus.busy, 1);
    bus.in_valid = 1'b1;
    bus.matrix = 1'b1;
    repeat (20) tick();
    bus.in_valid = 1'b0;
    tick();
    chk("wait_ignores_valid", wcnt, 128);
    scnt = 0;
    send_idx(4'b1010, 4'b0011);
    chk("idx_start", bus.mac_start, 1);
    chk("idx_i", bus.mac_i_idx, 4'hA);
    chk("idx_w", bus.mac_w_idx, 4'h3);
    chk("idx_busy", bus.busy, 1);
    tick();
    chk("start_one_cycle", bus.mac_start, 0);
    finish_round(1'b1);
    chk("round1_busy", bus.busy, 1);
    chk("round1_i_held", bus.mac_i_idx, 4'hA);
    for (int r = 2; r <= 16; r++) begin
      send_idx(r[3:0], ~r[3:0]);
      chk("rd_start", bus.mac_start, 1);
      chk("rd_i", bus.mac_i_idx, {28'd0, r[3:0]});
      tick();
      finish_round(r == 8);
      if (r == 15) chk("round15_busy", bus.busy, 1);
    end
    chk("rounds_starts", scnt, 16);
    chk("rounds_idle", bus.busy, 0);
    chk("rounds_w_held", bus.mac_w_idx, 4'hF);
    nn = 64; dbase = 16'h0000; wcnt = 0;
    for (int k = 0; k < 2048; k++) begin
      send_word(k[15:0], 2'b10);
      if (k == 2047) begin
        chk("s2_final_we", bus.mem_we, 1);
        chk("s2_final_addr", bus.mem_addr, 11'h7FF);
        chk("s2_final_data", bus.mem_wdata, 16'h07FF);
      end
    end
    bus.in_valid = 1'b0;
    tick();
    chk("s2_count", wcnt, 2048);
    chk("s2_size", bus.mac_size, 2'b10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    nn = 16; dbase = 16'hB000; wcnt = 0;
    send_word(16'hB000, 2'b01);
    send_word(16'hB001, 2'b01);
    for (int b = 15; b >= 7; b--) begin
      bus.matrix = b[0];
      tick();
    end
    chk("pre_rst_size", bus.mac_size, 2'b01);
    chk("pre_rst_addr", bus.mem_addr, 11'h001);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    tick();
    rst = 1'b0;
    chk("mid_rst_we", bus.mem_we, 0);
    chk("mid_rst_addr", bus.mem_addr, 0);
    chk("mid_rst_wdata", bus.mem_wdata, 0);
    chk("mid_rst_start", bus.mac_start, 0);
    chk("mid_rst_i", bus.mac_i_idx, 0);
    chk("mid_rst_w", bus.mac_w_idx, 0);
    chk("mid_rst_size", bus.mac_size, 0);
    chk("mid_rst_busy", bus.busy, 0);
    tick();
    chk("mid_rst_no_pending", wcnt, 2);
    wcnt = 0; dbase = 16'hC000;
    send_word(16'hC000, 2'b01);
    repeat (5) tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    chk("partial_dropped", wcnt, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
`ifdef MMSA_CTRL_PROTO_ERR_EN
    chk("perr_after_rst", bus.proto_err, 0);
`endif
    wcnt = 0; nn = 4; dbase = 16'h2222;
    send_word(16'h2222, 2'b00);
    bus.in_valid = 1'b0;
    tick();
`ifdef MMSA_CTRL_PROTO_ERR_EN
    chk("perr_clean_load", bus.proto_err, 0);
`endif
    scnt = 0;
    bus.in_valid2 = 1'b1;
    bus.i_mat_idx = 1'b1;
    bus.w_mat_idx = 1'b1;
    tick();
    tick();
    bus.in_valid2 = 1'b0;
    tick();
    tick();
    chk("abort_no_start", scnt, 0);
`ifdef MMSA_CTRL_PROTO_ERR_EN
    chk("perr_set", bus.proto_err, 1);
`endif
    send_idx(4'b0110, 4'b1001);
    chk("after_abort_i", bus.mac_i_idx, 4'h6);
    chk("after_abort_w", bus.mac_w_idx, 4'h9);
    repeat (5) tick();
`ifdef MMSA_CTRL_PROTO_ERR_EN
    chk("perr_sticky", bus.proto_err, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("perr_cleared", bus.proto_err, 0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mmsa_ctrl.md
MMSA_CTRL -- requirements
Module: mmsa_ctrl

Interface
REQ-001 The block SHALL have these ports, one per line as name, direction, width, meaning:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  matrix load window.
- matrix  in  1  serial element data, 16-bit words, MSB first.
- matrix_size  in  2  valid on first in_valid cycle; 00=2x2, 01=4x4, 10=8x8, 11=8x8.
- in_valid2  in  1  index window, 4 cycles per round.
- i_mat_idx, w_mat_idx  in  1 each  serial 4-bit indices, MSB first.
- mac_done  in  1  datapath round-complete pulse.
- mem_we  out  1  SRAM write strobe.
- mem_addr  out  11  {mat_no[4:0], elem[5:0]}.
- mem_wdata  out  16  assembled element.
- mac_start  out  1  one-cycle round start pulse.
- mac_i_idx, mac_w_idx  out  4 each  indices for the current round.
- mac_size  out  2  latched matrix_size.
- busy  out  1  high in every state except IDLE.

Function
REQ-002 The FSM SHALL have states IDLE, LOAD, WAIT_IDX, IDX, RUN, BUSY.
REQ-003 IDLE->LOAD when in_valid=1; matrix_size and the first matrix bit are sampled in that same cycle.
REQ-004 In LOAD, each in_valid cycle shifts matrix into a 16-bit shift register; after the 16th bit, mem_we=1 for exactly one cycle on the next cycle, with mem_wdata = word and mem_addr = current address.
REQ-005 Address order: elem increments 0..n*n-1 row-major, then mat_no increments; mat_no 0-15 = input matrices, 16-31 = weight matrices.
REQ-006 Words beyond 32*n*n SHALL be dropped (no mem_we).
REQ-007 LOAD->WAIT_IDX when in_valid=0; a partial word (<16 bits) is discarded; the round counter clears to 0.
REQ-008 WAIT_IDX->IDX when in_valid2=1, shifting the first index bits; IDX collects the remaining 3 bits.
REQ-009 If in_valid2 falls before 4 bits are collected, the FSM returns to WAIT_IDX and discards the partial indices.
REQ-010 After the 4th bit, the FSM enters RUN for one cycle: mac_start=1, and mac_i_idx/mac_w_idx are updated in the same cycle and held stable until the next RUN.
REQ-011 RUN->BUSY unconditionally; mac_done is ignored in every state other than BUSY.
REQ-012 On mac_done in BUSY, the round counter increments; counter reaching 16 -> IDLE, else -> WAIT_IDX.
REQ-013 in_valid or in_valid2 asserted in RUN or BUSY is ignored; in_valid in WAIT_IDX is ignored.
REQ-014 mac_size SHALL hold its latched value until the next IDLE->LOAD transition.

Reset
REQ-015 When rst=1 at a clock edge, the FSM goes to IDLE; all counters and shift registers clear; mem_we, mem_addr, mem_wdata, mac_start, mac_i_idx, mac_w_idx, mac_size, and busy go to 0 in the next cycle, regardless of state.
REQ-016 Reset asserted mid-word or mid-round SHALL leave no pending mem_we or mac_start.

Configuration
REQ-017 With MMSA_CTRL_PROTO_ERR_EN defined, the block SHALL add output proto_err (1 bit).
- proto_err is a sticky 1 on any REQ-006, REQ-007-partial-word, REQ-009, or REQ-013 event.
- proto_err is cleared only by rst.
REQ-018 Without the macro, the port and its logic SHALL be absent; all other behaviour is unchanged.

Verification
REQ-019 Size=00, 32 matrices x 4 words, word k = 16'h1000+k -> 128 mem_we pulses; addr 0,1,2,3,64,65,... (mat_no<<6 | elem); last pulse addr 11'h7C3, data 16'h107F.
REQ-020 Size=10, full load -> 2048 writes, final addr 11'h7FF, one cycle after the last bit.
REQ-021 in_valid2 4 cycles, i bits 1,0,1,0 and w bits 0,0,1,1 -> next cycle mac_start=1, mac_i_idx=4'hA, mac_w_idx=4'h3, busy=1.
REQ-022 16 rounds, each with mac_done 5 cycles after mac_start -> exactly 16 mac_start pulses, busy=0 after the 16th mac_done; in_valid2 during BUSY produces no extra start.
REQ-023 rst pulsed for 1 cycle after 9 bits of a word -> all outputs 0 next cycle; a fresh load then starts at addr 0.
REQ-024 With the macro: in_valid2 for 2 cycles then low -> no mac_start, proto_err=1 and held until rst.
